// File: rtl/lobster_dbus_arb.sv
// lobster_dbus_arb
//
// Data-bus arbiter and SRAM sequencer for the lobster core. NUM_CH requester
// channels (fetch, load, store, context DMA, ...) share one SRAM port. The
// port runs one transaction at a time. Arbitration is round-robin, with
// optional lock chaining that keeps the port on one channel. Misaligned
// addresses are rejected without an SRAM cycle. A stalled SRAM is abandoned
// after TIMEOUT cycles.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-low reset
//   req_valid   [NUM_CH]  per-channel request valid
//   req_ready   [NUM_CH]  per-channel accept (combinational, one-hot or zero)
//   req_we      [NUM_CH]  1 = store, 0 = load/fetch
//   req_lock    [NUM_CH]  keep the grant on this channel after this transaction
//   req_addr    packed byte addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata   packed store data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid  [NUM_CH]  one-cycle completion pulse
//   resp_err    misaligned or timed-out transaction, qualifies resp_valid
//   resp_rdata  load data, updated only by a completed load
//   ce, we     SRAM command / write enable
//   addr_in    SRAM read address,  data_in  SRAM read data
//   addr_out   SRAM write address, data_out SRAM write data
//   rdy        SRAM completion
//
// FSM states
//   state | meaning
//   IDLE  | port free; arbitrate, accept one request per cycle
//   BUSY  | SRAM command driven, waiting for rdy or timeout

module lobster_dbus_arb #(
  parameter int ADDR_WIDTH = 36,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_we,
  input  logic [NUM_CH-1:0]            req_lock,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CH-1:0]            resp_valid,
  output logic                         resp_err,
  output logic [DATA_WIDTH-1:0]        resp_rdata,
  output logic                         ce,
  output logic                         we,
  output logic [ADDR_WIDTH-1:0]        addr_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [ADDR_WIDTH-1:0]        addr_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  input  logic                         rdy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Low address bits that must be zero for a word-aligned access. An 8-bit
  // bus gives an all-zero mask, so nothing is ever misaligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((DATA_WIDTH / 8) - 1);

  // Counter value at which the next rdy-low BUSY edge is the TIMEOUT-th one.
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   lock_owner;
  logic            lock_held;
  logic [CW-1:0]   cur_ch;
  logic            cur_we;
  logic [TW-1:0]   tmo_cnt;

  logic                  lock_hit;
  logic                  win_found;
  logic [CW-1:0]         win_ch;
  logic                  win_we;
  logic                  win_lock;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_misaligned;
  logic [CW-1:0]         rr_next;
  int                    rr_idx;

  // Grant selection. A live lock owner bypasses the round-robin search. An
  // owner that has dropped req_valid loses priority in this same cycle.
  always_comb begin
    lock_hit  = lock_held && req_valid[lock_owner];
    win_found = 1'b0;
    win_ch    = '0;
    rr_idx    = 0;
    if (state == IDLE) begin
      if (lock_hit) begin
        win_found = 1'b1;
        win_ch    = lock_owner;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          rr_idx = (int'(rr_ptr) + i) % NUM_CH;
          if (!win_found && req_valid[rr_idx]) begin
            win_found = 1'b1;
            win_ch    = CW'(rr_idx);
          end
        end
      end
    end
  end

  // Mux the winning channel's request fields.
  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CW'(i) == win_ch) begin
        win_we    = req_we[i];
        win_lock  = req_lock[i];
        win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (win_found) begin
      req_ready[win_ch] = 1'b1;
    end
  end

  assign win_misaligned = |(win_addr & ALIGN_MASK);

  always_comb begin
    if (int'(win_ch) == NUM_CH - 1) begin
      rr_next = '0;
    end else begin
      rr_next = win_ch + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_owner <= '0;
      lock_held  <= 1'b0;
      cur_ch     <= '0;
      cur_we     <= 1'b0;
      tmo_cnt    <= '0;
      ce         <= 1'b0;
      we         <= 1'b0;
      addr_in    <= '0;
      addr_out   <= '0;
      data_out   <= '0;
      resp_valid <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      // Response flags are single-cycle pulses.
      resp_valid <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cur_ch     <= win_ch;
            cur_we     <= win_we;
            lock_held  <= win_lock;
            lock_owner <= win_ch;
            // A locking winner keeps the pointer so that round-robin resumes
            // from the same place once the chain ends.
            if (!win_lock) begin
              rr_ptr <= rr_next;
            end
            if (win_misaligned) begin
              resp_valid[win_ch] <= 1'b1;
              resp_err           <= 1'b1;
            end else begin
              state    <= BUSY;
              ce       <= 1'b1;
              we       <= win_we;
              addr_in  <= win_we ? '0 : win_addr;
              addr_out <= win_we ? win_addr : '0;
              data_out <= win_we ? win_wdata : '0;
              tmo_cnt  <= '0;
            end
          end else if (lock_held && !req_valid[lock_owner]) begin
            lock_held <= 1'b0;
          end
        end

        BUSY: begin
          // rdy takes priority over a timeout that expires on the same edge.
          if (rdy) begin
            state              <= IDLE;
            ce                 <= 1'b0;
            we                 <= 1'b0;
            addr_in            <= '0;
            addr_out           <= '0;
            data_out           <= '0;
            resp_valid[cur_ch] <= 1'b1;
            if (!cur_we) begin
              resp_rdata <= data_in;
            end
          end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
            state              <= IDLE;
            ce                 <= 1'b0;
            we                 <= 1'b0;
            addr_in            <= '0;
            addr_out           <= '0;
            data_out           <= '0;
            resp_valid[cur_ch] <= 1'b1;
            resp_err           <= 1'b1;
            lock_held          <= 1'b0;
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lobster_dbus_arb.sv
// Directed bench for lobster_dbus_arb (NUM_CH=3, DATA_WIDTH=64, TIMEOUT=4).
// A table of single transactions covers latency, data paths, alignment and
// timeout. Hand-written sequences cover reset, round-robin and lock chaining.

module tb_lobster_dbus_arb;

  localparam int AW = 36;
  localparam int DW = 64;
  localparam int NC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   req_valid;
  logic [NC-1:0]   req_ready;
  logic [NC-1:0]   req_we;
  logic [NC-1:0]   req_lock;
  logic [NC*AW-1:0] req_addr;
  logic [NC*DW-1:0] req_wdata;
  logic [NC-1:0]   resp_valid;
  logic            resp_err;
  logic [DW-1:0]   resp_rdata;
  logic            ce;
  logic            we;
  logic [AW-1:0]   addr_in;
  logic [DW-1:0]   data_in;
  logic [AW-1:0]   addr_out;
  logic [DW-1:0]   data_out;
  logic            rdy;

  lobster_dbus_arb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_CH(NC),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_lock(req_lock),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .ce(ce),
    .we(we),
    .addr_in(addr_in),
    .data_in(data_in),
    .addr_out(addr_out),
    .data_out(data_out),
    .rdy(rdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            ch;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rdy_at;     // cycle after handshake with rdy high, 0 = never
    logic [DW-1:0] din;
    int            exp_lat;    // cycles from handshake to resp_valid
    logic          exp_err;
    logic          exp_ce;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int ch, input logic w, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[ch]              = w;
    req_lock[ch]            = lk;
    req_addr[ch*AW +: AW]   = a;
    req_wdata[ch*DW +: DW]  = d;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic          got;
    int            lat;
    int            quiet_bad;
    logic          ce_seen;
    logic          ce_at_resp;
    logic          err_s;
    logic          we_s;
    logic [NC-1:0] rv_s;
    logic [DW-1:0] rd_s;
    logic [DW-1:0] dout_s;
    logic [AW-1:0] ain_s;
    logic [AW-1:0] aout_s;
    got = 1'b0; lat = -1; quiet_bad = 0; ce_seen = 1'b0; ce_at_resp = 1'b1;
    err_s = 1'b0; we_s = 1'b0; rv_s = '0; rd_s = '0; dout_s = '0;
    ain_s = '0; aout_s = '0;

    @(negedge clk);
    rdy = 1'b0;
    set_req(v.ch, v.we, 1'b0, v.addr, v.wdata);
    req_valid = '0;
    req_valid[v.ch] = 1'b1;
    for (int w = 0; w < 8; w++) begin
      #1;
      if (req_ready[v.ch]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d_handshake", idx), got, 1);

    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      req_valid = '0;
      rdy = (k == v.rdy_at);
      data_in = (k == v.rdy_at) ? v.din : '1;
      #1;
      if (ce && !ce_seen) begin
        ce_seen = 1'b1;
        we_s = we; ain_s = addr_in; aout_s = addr_out; dout_s = data_out;
      end
      if (resp_valid != '0) begin
        lat = k; rv_s = resp_valid; err_s = resp_err; rd_s = resp_rdata;
        ce_at_resp = ce;
        break;
      end
      if (resp_err) quiet_bad++;
    end
    rdy = 1'b0;

    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_resp_valid", idx), rv_s, 64'(1) << v.ch);
    chk($sformatf("v%0d_resp_err", idx), err_s, v.exp_err);
    chk($sformatf("v%0d_resp_rdata", idx), rd_s, v.exp_rdata);
    chk($sformatf("v%0d_ce_seen", idx), ce_seen, v.exp_ce);
    chk($sformatf("v%0d_ce_after", idx), ce_at_resp, 0);
    chk($sformatf("v%0d_err_quiet", idx), quiet_bad, 0);
    if (ce_seen) begin
      chk($sformatf("v%0d_we", idx), we_s, v.we);
      chk($sformatf("v%0d_addr_in", idx), ain_s, v.we ? 36'h0 : v.addr);
      chk($sformatf("v%0d_addr_out", idx), aout_s, v.we ? v.addr : 36'h0);
      chk($sformatf("v%0d_data_out", idx), dout_s, v.we ? v.wdata : 64'h0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_ch[4];
    int g_cyc[4];
    int r_ch[4];
    int r_cyc[4];
    int ng;
    int nr;
    int oh_bad;
    int err_bad;
    int n2;
    int bad;

    //             ch we    addr             wdata                  rdy din                    lat err   ce    rdata
    vt[0] = '{0, 1'b0, 36'h0_0000_1000, 64'h0,                  1, 64'hDEADBEEF_00C0FFEE, 2, 1'b0, 1'b1, 64'hDEADBEEF_00C0FFEE};
    vt[1] = '{1, 1'b0, 36'h0_0000_1003, 64'h0,                  0, 64'h0,                 1, 1'b1, 1'b0, 64'hDEADBEEF_00C0FFEE};
    vt[2] = '{2, 1'b1, 36'h0_0000_2008, 64'h11223344_55667788,  2, 64'h0,                 3, 1'b0, 1'b1, 64'hDEADBEEF_00C0FFEE};
    vt[3] = '{0, 1'b0, 36'h0_0000_0040, 64'h0,                  3, 64'h01234567_89ABCDEF, 4, 1'b0, 1'b1, 64'h01234567_89ABCDEF};
    vt[4] = '{1, 1'b0, 36'h0_0000_3000, 64'h0,                  0, 64'h0,                 5, 1'b1, 1'b1, 64'h01234567_89ABCDEF};
    vt[5] = '{0, 1'b0, 36'h0_0000_3008, 64'h0,                  4, 64'hCAFEF00D_12345678, 5, 1'b0, 1'b1, 64'hCAFEF00D_12345678};
    vt[6] = '{2, 1'b1, 36'h0_0000_2004, 64'h99999999_99999999,  0, 64'h0,                 1, 1'b1, 1'b0, 64'hCAFEF00D_12345678};
    vt[7] = '{1, 1'b1, 36'hF_FFFF_FFF8, 64'h5A5A5A5A_A5A5A5A5,  1, 64'h0,                 2, 1'b0, 1'b1, 64'hCAFEF00D_12345678};

    rst = 1'b0;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    data_in = '0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ce", ce, 0);
    chk("reset_we", we, 0);
    chk("reset_addr_in", addr_in, 0);
    chk("reset_addr_out", addr_out, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_err", resp_err, 0);
    chk("reset_resp_rdata", resp_rdata, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vt[i], i);
    end

    // Reset asserted in the middle of a BUSY load on ch1.
    @(negedge clk);
    rdy = 1'b0;
    set_req(1, 1'b0, 1'b0, 36'h100, 64'h0);
    req_valid = 3'b010;
    #1;
    chk("rst_seq_grant", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rst_seq_busy_ce", ce, 1);
    rst = 1'b0;
    #1;
    chk("rst_seq_ce_async", ce, 0);
    chk("rst_seq_addr_in_async", addr_in, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // rdy pulses in IDLE after reset must not produce a response.
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy = 1'b1;
      #1;
      if (resp_valid != '0 || ce) bad++;
    end
    chk("rst_seq_no_resp", bad, 0);

    // Round-robin with every channel valid and rdy tied high.
    set_req(0, 1'b0, 1'b0, 36'h10, 64'h0);
    set_req(1, 1'b0, 1'b0, 36'h18, 64'h0);
    set_req(2, 1'b0, 1'b0, 36'h20, 64'h0);
    for (int i = 0; i < 4; i++) begin
      g_ch[i] = -1; g_cyc[i] = -1; r_ch[i] = -1; r_cyc[i] = -1;
    end
    ng = 0; nr = 0; oh_bad = 0; err_bad = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 3'b111;
      else if (ng == 4) req_valid = '0;
      #1;
      if (!$onehot0(req_ready)) oh_bad++;
      if (resp_valid != '0 && nr < 4) begin
        r_ch[nr] = oh_idx(resp_valid);
        r_cyc[nr] = c;
        if (resp_err) err_bad++;
        nr++;
      end
      if (req_ready != '0 && ng < 4) begin
        g_ch[ng] = oh_idx(req_ready);
        g_cyc[ng] = c;
        ng++;
      end
    end
    chk("rr_grant_count", ng, 4);
    chk("rr_resp_count", nr, 4);
    chk("rr_ready_onehot", oh_bad, 0);
    chk("rr_resp_err", err_bad, 0);
    chk("rr_grant0", g_ch[0], 0);
    chk("rr_grant1", g_ch[1], 1);
    chk("rr_grant2", g_ch[2], 2);
    chk("rr_grant3", g_ch[3], 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant_cycle%0d", i), g_cyc[i], 2 * i);
      chk($sformatf("rr_resp_cycle%0d", i), r_cyc[i], 2 * i + 2);
      chk($sformatf("rr_resp_ch%0d", i), r_ch[i], (i == 3) ? 0 : i);
    end

    // Lock chain: ch2 locked store, then unlocked store, while ch0/ch1 wait.
    for (int i = 0; i < 4; i++) g_ch[i] = -1;
    ng = 0; n2 = 0;
    for (int c = 0; c < 12 && ng < 3; c++) begin
      @(negedge clk);
      set_req(2, 1'b1, (n2 == 0), (n2 == 0) ? 36'h500 : 36'h508,
              (n2 == 0) ? 64'hA5A5A5A5_00000001 : 64'hA5A5A5A5_00000002);
      req_valid[2] = (n2 < 2);
      req_valid[0] = (c >= 1);
      req_valid[1] = (c >= 1);
      #1;
      if (c == 1) begin
        chk("lock_st1_ce", ce, 1);
        chk("lock_st1_addr_out", addr_out, 36'h500);
        chk("lock_st1_data_out", data_out, 64'hA5A5A5A5_00000001);
      end
      if (c == 3) begin
        chk("lock_st2_addr_out", addr_out, 36'h508);
        chk("lock_st2_data_out", data_out, 64'hA5A5A5A5_00000002);
      end
      if (req_ready != '0) begin
        g_ch[ng] = oh_idx(req_ready);
        if (g_ch[ng] == 2) n2++;
        ng++;
      end
    end
    chk("lock_grant_count", ng, 3);
    chk("lock_grant0", g_ch[0], 2);
    chk("lock_grant1", g_ch[1], 2);
    chk("lock_grant2", g_ch[2], 0);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    #1;
    chk("lock_drain_ce", ce, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lobster_dbus_arb.md
# lobster_dbus_arb

Parametrised data-bus arbiter and SRAM sequencer for the lobster core. It replaces the single hard-wired fetch/load/store access path with NUM_CH independent requester channels (fetch, load, store, task-context DMA, ...). Channels are served one transaction at a time on the shared SRAM port using round-robin arbitration. The block also provides atomic lock chaining, alignment checking and a ready-timeout.

## Interface
- ADDR_WIDTH, 36: byte address width.
- DATA_WIDTH, 64: data word width; must be a power of two and at least 8.
- NUM_CH, 3: number of requester channels, 1..8.
- TIMEOUT, 255: maximum BUSY cycles without `rdy`; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel accept; combinational; one-hot or zero.
- req_we  in  NUM_CH  1 = store, 0 = load/fetch.
- req_lock  in  NUM_CH  keep the grant on this channel after this transaction.
- req_addr  in  NUM_CH*ADDR_WIDTH  packed addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_CH*DATA_WIDTH  packed store data.
- resp_valid  out  NUM_CH  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned address or timeout.
- resp_rdata  out  DATA_WIDTH  load data; valid with resp_valid for loads only.
- ce  out  1  SRAM command enable.
- we  out  1  SRAM write enable.
- addr_in  out  ADDR_WIDTH  SRAM read address.
- data_in  in  DATA_WIDTH  SRAM read data.
- addr_out  out  ADDR_WIDTH  SRAM write address.
- data_out  out  DATA_WIDTH  SRAM write data.
- rdy  in  1  SRAM completion.

## Operation
- **States:** IDLE, BUSY.
- **Grant in IDLE:**
  - If a lock is held and the lock-owner's req_valid is set, the grant goes to that owner.
  - Otherwise a round-robin search starts at rr_ptr and takes the first asserted req_valid.
  - req_ready of the winner is 1 in that same cycle. Handshake = req_valid & req_ready.
- **On handshake:** the block latches channel, we, addr, wdata and lock.
  - rr_ptr becomes (winner+1) mod NUM_CH, unless the winner has req_lock=1.
  - Lock owner = winner if req_lock=1; the lock is cleared otherwise.
- **Alignment check:** an address is misaligned when any of its low log2(DATA_WIDTH/8) bits is set.
  - Misaligned request: stay in IDLE, no SRAM cycle.
  - Next cycle: resp_valid[ch]=1 and resp_err=1.
- **Aligned request:** go to BUSY.
  - ce=1; we=latched we.
  - Load: addr_in=addr, addr_out=0.
  - Store: addr_out=addr, data_out=wdata, addr_in=0.
- **In BUSY:**
  - rdy sampled high: leave to IDLE; ce, we, addr_in, addr_out and data_out return to 0.
  - In the following cycle resp_valid[ch]=1 and resp_err=0; for loads, resp_rdata=data_in captured at that edge.
- **Timeout:** the counter clears on BUSY entry and increments on each BUSY edge with rdy low.
  - When it reaches TIMEOUT: go to IDLE with resp_valid[ch]=1 and resp_err=1.
  - The lock is cleared.
- **Lock release:** a held lock is also released when the owner drops req_valid while in IDLE; normal round-robin resumes that cycle.
- **Stray rdy:** rdy in IDLE is ignored.
- **Output stability:** resp_rdata holds its value until the next load completes; resp_err is 0 when no resp_valid is asserted.

## Timing
- **Reset (rst low, asynchronous):** values below; any in-flight transaction is dropped without a response.
  - State IDLE, rr_ptr=0, lock cleared, counter 0.
  - ce, we, addr_in, addr_out and data_out = 0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
- **Latency:**
  - Handshake in cycle t: ce=1 in t+1.
  - rdy high in cycle t+k (k≥1): resp_valid in t+k+1.
  - Minimum 2 cycles per transaction.
- **Back-to-back:** a new handshake is allowed in the same cycle resp_valid is asserted. The next ce then rises in the cycle after that, so ce is low for exactly one cycle between transactions.
- **Simultaneous rdy and timeout** in the same cycle: rdy wins, and the response is non-error.
- **Single channel:** with NUM_CH=1, rr_ptr stays 0 and lock has no effect on the grant.
- **All outputs are registered except req_ready.**

## Test plan
- **Reset:** hold rst=0 mid-BUSY (ch1 load at 0x100). Required: ce=0 immediately; after release no resp_valid is seen; the first grant goes to ch0 when ch0 and ch1 are both valid.
- **Single load:** ch0 reads 0x1000, rdy high one cycle after ce, data_in=0xDEADBEEF_00C0FFEE. Required: resp_valid[0] 2 cycles after the handshake, resp_err=0, resp_rdata=0xDEADBEEF_00C0FFEE.
- **Round-robin:** ch0, ch1 and ch2 all valid continuously with rdy tied to 1. Required: grant order 0,1,2,0; one resp_valid every 2 cycles.
- **Lock chain:** ch2 issues a store with req_lock=1 while ch0 and ch1 wait, then a store with req_lock=0. Required: both ch2 stores complete before either ch0 or ch1 is granted; the next grant is ch0.
- **Misaligned access:** ch1 loads 0x1003 with DATA_WIDTH=64. Required: ce never rises; resp_valid[1]=1 and resp_err=1 one cycle after the handshake.
- **Timeout:** TIMEOUT=4, ch0 load, rdy held 0. Required: error response in the cycle after the 4th BUSY edge; ce=0 afterwards. A rerun with rdy rising on that same 4th edge returns resp_err=0.
